corelet_seq: RTL and testbench
==============================

Name: corelet_seq

Overview:
- FSM sequencer that drives the corelet 34-bit instruction word and the activation/psum SRAM strobes.
- Runs one tile end to end:
  - load kernel rows from xmem into L0, then shift them into the MAC array;
  - load num_act activation vectors, then execute;
  - drain the OFIFO into pmem.
- Sits beside the corelet in the core top; replaces hand-driven testbench instruction streams.

Parameters:
- row, 8, MAC array rows / L0 width in vectors
- col, 8, MAC array columns / OFIFO width
- len_bw, 8, width of num_act
- addr_bw, 11, SRAM address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  tile start pulse; honoured only in IDLE
- num_act  in  len_bw  activation vectors per tile; sampled at start
- acc_en  in  1  accumulate into existing psum; sampled at start
- w_base  in  addr_bw  xmem base of kernel rows; sampled at start
- x_base  in  addr_bw  xmem base of activations; sampled at start
- p_base  in  addr_bw  pmem base of outputs; sampled at start
- l0_full  in  1  L0 almost-full (asserts with one free entry)
- ofifo_valid  in  1  OFIFO holds at least one complete row
- inst  out  34  corelet instruction word
  - [1:0] mac inst: 01 kernel load, 10 execute
  - [2] l0_wr, [3] l0_rd, [6] ofifo_rd, [33] sfp acc
  - all other bits are always 0
- xmem_rd  out  1  xmem read enable; data is valid on coreletIn one cycle later
- xmem_addr  out  addr_bw  xmem address
- pmem_wr  out  1  pmem write enable
- pmem_addr  out  addr_bw  pmem address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset: all outputs 0; state=IDLE; counters=0. Reset mid-tile aborts immediately with no further strobes.
- All outputs are registered.
- IDLE:
  - start=1 and num_act!=0: latch the sampled inputs, cnt=0, go to KLOAD.
  - start with num_act==0 is ignored.
  - start in any other state is ignored.
- KLOAD: issue row reads.
  - Cycle k: xmem_rd=1, xmem_addr=w_base+k.
  - Cycle k+1: l0_wr=1.
  - A read is issued only while l0_full=0; cnt holds otherwise.
  - The in-flight word is always written (this is why L0 full is wired one entry early).
  - Leave after the last write (row reads plus a 1-cycle tail).
- KSHIFT:
  - row cycles of l0_rd=1, inst[1:0]=01;
  - then col cycles of inst=0 (weight propagation).
- ALOAD: same as KLOAD, with num_act reads at x_base+k.
- EXEC: num_act cycles of l0_rd=1, inst[1:0]=10; then go to DRAIN.
- DRAIN: outputs idle; cnt=0. Go to OREAD when ofifo_valid=1.
- OREAD:
  - Each cycle with ofifo_valid=1 and cnt<num_act: ofifo_rd=1, cnt++.
  - One cycle later: pmem_wr=1, pmem_addr=p_base+(cnt-1).
  - inst[33]=acc_en is held high for the whole state.
  - When ofifo_valid drops: stall with no strobe.
  - After the final pmem_wr go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- Widths and ranges:
  - Address adders wrap modulo 2^addr_bw.
  - num_act up to 2^len_bw-1 with no overflow; counters are len_bw+1 bits.
- Latency with no stalls, cycles from start to done:
  - 1 + (row+1) + (row+col) + (num_act+1) + num_act + DRAIN wait + (num_act+1) + 1.

Optional Feature:
- Macro: CORELET_SEQ_PERF_EN.
- With the macro defined, two extra outputs:
  - perf_cycles (32 bits): counts cycles with busy=1.
  - perf_stalls (32 bits): counts cycles stalled on l0_full or !ofifo_valid.
- Both counters clear on reset and on accepted start, and saturate at all-ones.
- Without the macro, the ports and logic are absent.

Test Plan:
1. Reset mid-EXEC -> next cycle: inst=0, busy=0, no pmem_wr; then start with num_act=4 completes normally.
2. start with num_act=4, w_base=0, x_base=16, p_base=0, no stalls:
   - xmem_addr sequences 0..7, then 16..19;
   - exactly 8 cycles of inst[1:0]=01, 4 of 10, 4 ofifo_rd, 4 pmem_wr at 0..3;
   - done exactly once; measured latency matches the formula.
3. l0_full held high for 3 cycles during KLOAD -> xmem_rd low for those 3 cycles, no duplicate addresses, exactly 8 l0_wr total.
4. ofifo_valid toggling 1,0,0,1,... in OREAD -> ofifo_rd only on valid cycles; pmem_addr strictly increments; 4 writes total.
5. acc_en=1 -> inst[33]=1 throughout OREAD and 0 elsewhere; start pulses during busy and start with num_act=0 in IDLE produce no activity.

Source files
------------

// File: rtl/corelet_seq_if.sv
// Control/status bundle between corelet_seq and its surroundings: tile command,
// L0/OFIFO flow control, corelet instruction word and SRAM strobes.
interface corelet_seq_if #(
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
);
  logic                start;
  logic [len_bw-1:0]   num_act;
  logic                acc_en;
  logic [addr_bw-1:0]  w_base;
  logic [addr_bw-1:0]  x_base;
  logic [addr_bw-1:0]  p_base;
  logic                l0_full;
  logic                ofifo_valid;
  logic [33:0]         inst;
  logic                xmem_rd;
  logic [addr_bw-1:0]  xmem_addr;
  logic                pmem_wr;
  logic [addr_bw-1:0]  pmem_addr;
  logic                busy;
  logic                done;

  modport master (
    output start, num_act, acc_en, w_base, x_base, p_base, l0_full, ofifo_valid,
    input  inst, xmem_rd, xmem_addr, pmem_wr, pmem_addr, busy, done
  );
  modport slave (
    input  start, num_act, acc_en, w_base, x_base, p_base, l0_full, ofifo_valid,
    output inst, xmem_rd, xmem_addr, pmem_wr, pmem_addr, busy, done
  );
endinterface

// File: rtl/corelet_seq.sv
// Tile sequencer: kernel load/shift, activation load/execute, OFIFO drain to pmem.
// Optional CORELET_SEQ_PERF_EN adds saturating busy-cycle and stall counters.
module corelet_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic clk,
  input  logic reset,
  corelet_seq_if.slave bus
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);
  localparam int CW = len_bw + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, KLOAD, KSHIFT, ALOAD, EXEC, DRAIN, OREAD, DONE} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d, n_q, ld_len;
  logic                acc_q, accept;
  logic [addr_bw-1:0]  w_q, x_q, p_q;

  // next-cycle output values
  logic                xrd_d, l0rd_d, ord_d, acc_d, busy_d, done_d;
  logic [1:0]          mac_d;
  logic [addr_bw-1:0]  xaddr_d, paddr_d;

  // [0] strobe, [1] same strobe one cycle later (the write of the fetched word)
  logic [1:0]          xrd_pipe, ord_pipe;
  logic                l0_rd_q, acc_o, busy_q, done_q;
  logic [1:0]          mac_q;
  logic [addr_bw-1:0]  xmem_addr_q, pa_stage, pmem_addr_q;

  assign accept = (state == IDLE) && bus.start && (bus.num_act != '0);
  assign ld_len = (state == KLOAD) ? CW'(row) : n_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      n_q   <= '0;
      acc_q <= 1'b0;
      w_q   <= '0;
      x_q   <= '0;
      p_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        n_q   <= {1'b0, bus.num_act};
        acc_q <= bus.acc_en;
        w_q   <= bus.w_base;
        x_q   <= bus.x_base;
        p_q   <= bus.p_base;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:   if (accept) begin state_d = KLOAD; cnt_d = '0; end
      KLOAD, ALOAD:
        // last cycle is the tail that lets the final fetched word land in L0
        if (cnt == ld_len) begin
          state_d = (state == KLOAD) ? KSHIFT : EXEC;
          cnt_d   = '0;
        end else if (!bus.l0_full) cnt_d = cnt + ONE;
      KSHIFT:
        if (cnt == CW'(row + col - 1)) begin state_d = ALOAD; cnt_d = '0; end
        else cnt_d = cnt + ONE;
      EXEC:
        if (cnt == n_q - ONE) begin state_d = DRAIN; cnt_d = '0; end
        else cnt_d = cnt + ONE;
      DRAIN: begin
        cnt_d = '0;
        if (bus.ofifo_valid) state_d = OREAD;
      end
      OREAD:
        if (cnt == n_q) state_d = DONE;
        else if (bus.ofifo_valid) cnt_d = cnt + ONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    xrd_d   = (state == KLOAD || state == ALOAD) && (cnt != ld_len) && !bus.l0_full;
    xaddr_d = '0;
    if (xrd_d) xaddr_d = ((state == KLOAD) ? w_q : x_q) + addr_bw'(cnt);
    l0rd_d  = ((state == KSHIFT) && (cnt < CW'(row))) || (state == EXEC);
    mac_d   = 2'b00;
    if (state == KSHIFT && cnt < CW'(row)) mac_d = 2'b01;
    else if (state == EXEC)                mac_d = 2'b10;
    ord_d   = (state == OREAD) && (cnt != n_q) && bus.ofifo_valid;
    paddr_d = p_q + addr_bw'(cnt);
    acc_d   = (state == OREAD) && acc_q;
    busy_d  = (state != IDLE);
    done_d  = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xrd_pipe    <= '0;
      ord_pipe    <= '0;
      xmem_addr_q <= '0;
      pa_stage    <= '0;
      pmem_addr_q <= '0;
      l0_rd_q     <= 1'b0;
      mac_q       <= '0;
      acc_o       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      xrd_pipe    <= {xrd_pipe[0], xrd_d};
      ord_pipe    <= {ord_pipe[0], ord_d};
      xmem_addr_q <= xaddr_d;
      pa_stage    <= paddr_d;
      pmem_addr_q <= ord_pipe[0] ? pa_stage : '0;
      l0_rd_q     <= l0rd_d;
      mac_q       <= mac_d;
      acc_o       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.inst      = {acc_o, 26'd0, ord_pipe[0], 2'b00, l0_rd_q, xrd_pipe[1], mac_q};
  assign bus.xmem_rd   = xrd_pipe[0];
  assign bus.xmem_addr = xmem_addr_q;
  assign bus.pmem_wr   = ord_pipe[1];
  assign bus.pmem_addr = pmem_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef CORELET_SEQ_PERF_EN
  logic stall;
  assign stall = ((state == KLOAD || state == ALOAD) && (cnt != ld_len) && bus.l0_full) ||
                 ((state == OREAD) && (cnt != n_q) && !bus.ofifo_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy_q && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (stall  && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: expected SRAM addresses are queued per tile,
// a negedge monitor pops/compares strobes and tallies instruction activity.
module tb_corelet_seq;
  localparam int ROW = 8, COL = 8, LEN_BW = 8, ADDR_BW = 11;
  localparam logic [33:0] ALLOWED = 34'h2_0000_004F;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  corelet_seq_if #(.len_bw(LEN_BW), .addr_bw(ADDR_BW)) bus();
`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  corelet_seq #(.row(ROW), .col(COL), .len_bw(LEN_BW), .addr_bw(ADDR_BW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef CORELET_SEQ_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cyc = 0;
  int n_l0wr, n_k, n_e, n_ord, n_pw, n_acc, n_done;
  bit mon_en = 1'b0, exp_acc = 1'b0, prev_full = 1'b0, prev_vld = 1'b0;
  logic [ADDR_BW-1:0] xq[$], pq[$], e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("inst_reserved_bits", bus.inst & ~ALLOWED, 0);
      if (bus.xmem_rd) begin
        chk("xmem_rd_while_full", prev_full, 0);
        if (xq.size() == 0) chk("xmem_rd_extra", 1, 0);
        else begin e = xq.pop_front(); chk("xmem_addr", bus.xmem_addr, e); end
      end
      if (bus.pmem_wr) begin
        n_pw++;
        if (pq.size() == 0) chk("pmem_wr_extra", 1, 0);
        else begin e = pq.pop_front(); chk("pmem_addr", bus.pmem_addr, e); end
      end
      if (bus.inst[6]) begin
        n_ord++;
        chk("ofifo_rd_invalid", prev_vld, 1);
        chk("acc_during_oread", bus.inst[33], exp_acc);
      end
      if (bus.inst[3] || bus.inst[2] || bus.xmem_rd) chk("acc_outside_oread", bus.inst[33], 0);
      if (bus.inst[2]) n_l0wr++;
      if (bus.inst[1:0] == 2'b01) n_k++;
      if (bus.inst[1:0] == 2'b10) n_e++;
      if (bus.inst[33]) n_acc++;
      if (bus.done) begin n_done++; done_cyc = cyc; end
    end
    prev_full = bus.l0_full;
    prev_vld  = bus.ofifo_valid;
  end

  // mode 0: no stalls (plus an ignored start mid-tile), 1: l0_full for 3 KLOAD cycles,
  // 2: ofifo_valid 1,0,0 pattern, 3: random stalls, 4: reset once EXEC is seen
  task automatic run_tile(input int n, input bit acc, input logic [ADDR_BW-1:0] wb, xb, pb,
                          input int mode);
    logic [ADDR_BW-1:0] a;
    int t, start_cyc, lat, base_lat;
    base_lat = 1 + (ROW + 1) + (ROW + COL) + (n + 1) + n + 1 + (n + 1) + 1;
    for (int k = 0; k < ROW; k++) begin a = wb + ADDR_BW'(k); xq.push_back(a); end
    for (int k = 0; k < n; k++) begin
      a = xb + ADDR_BW'(k); xq.push_back(a);
      a = pb + ADDR_BW'(k); pq.push_back(a);
    end
    n_l0wr = 0; n_k = 0; n_e = 0; n_ord = 0; n_pw = 0; n_acc = 0; n_done = 0;
    exp_acc = acc;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_act = LEN_BW'(n); bus.acc_en = acc;
    bus.w_base = wb; bus.x_base = xb; bus.p_base = pb;
    bus.l0_full = 1'b0; bus.ofifo_valid = 1'b1;
    start_cyc = cyc;
    t = 0;
    while (n_done == 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
      bus.start = (mode == 0 && t == 20);
      if (mode == 0 && t == 20) begin bus.num_act = 8'd2; bus.w_base = wb + 11'd100; end
      case (mode)
        1: bus.l0_full = (t >= 3 && t <= 5);
        2: bus.ofifo_valid = (t % 3 == 0);
        3: begin
          bus.l0_full     = ($urandom_range(3) == 0);
          bus.ofifo_valid = ($urandom_range(9) < 6);
        end
        default: ;
      endcase
      if (mode == 4 && bus.inst[1:0] == 2'b10) begin
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("abort_inst", bus.inst, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_pmem_wr", bus.pmem_wr, 0);
        @(posedge clk); #1;
        chk("abort_pmem_wr_next", bus.pmem_wr, 0);
        chk("abort_xmem_rd_next", bus.xmem_rd, 0);
        reset = 1'b0;
        xq.delete(); pq.delete();
        mon_en = 1'b1;
        return;
      end
    end
    bus.start = 1'b0; bus.l0_full = 1'b0; bus.ofifo_valid = 1'b1;
    if (n_done == 0) begin
      chk("tile_timeout", 0, 1);
      xq.delete(); pq.delete();
      return;
    end
    repeat (3) @(posedge clk);
    #1;
    lat = done_cyc - start_cyc;
    chk("xmem_reads_missing", xq.size(), 0);
    chk("pmem_writes_missing", pq.size(), 0);
    chk("l0_wr_count", n_l0wr, ROW + n);
    chk("kernel_load_count", n_k, ROW);
    chk("exec_count", n_e, n);
    chk("ofifo_rd_count", n_ord, n);
    chk("pmem_wr_count", n_pw, n);
    chk("done_count", n_done, 1);
    chk("busy_after_done", bus.busy, 0);
    if (mode == 0) begin
      chk("latency", lat, base_lat);
      chk("acc_cycles", n_acc, acc ? n + 1 : 0);
    end
    if (mode == 1) chk("latency_l0_stall", lat, base_lat + 3);
`ifdef CORELET_SEQ_PERF_EN
    if (mode == 0) begin
      chk("perf_cycles", perf_cycles, lat - 1);
      chk("perf_stalls", perf_stalls, 0);
    end
    if (mode == 1) chk("perf_stalls_l0", perf_stalls, 3);
`endif
  endtask

  initial begin
    bus.start = 1'b0; bus.num_act = '0; bus.acc_en = 1'b0;
    bus.w_base = '0; bus.x_base = '0; bus.p_base = '0;
    bus.l0_full = 1'b0; bus.ofifo_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", bus.inst, 0);
    chk("rst_xmem_rd", bus.xmem_rd, 0);
    chk("rst_xmem_addr", bus.xmem_addr, 0);
    chk("rst_pmem_wr", bus.pmem_wr, 0);
    chk("rst_pmem_addr", bus.pmem_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    run_tile(4, 1'b0, 11'd0,  11'd16, 11'd0,   4);
    run_tile(4, 1'b0, 11'd0,  11'd16, 11'd0,   0);
    run_tile(4, 1'b0, 11'd32, 11'd48, 11'd100, 1);
    run_tile(4, 1'b0, 11'd0,  11'd16, 11'd8,   2);
    run_tile(4, 1'b1, 11'd5,  11'd20, 11'd30,  0);

    // start with num_act==0 must be ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_act = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_len_busy", bus.busy, 0);
    end

    run_tile(5, 1'b1, 11'h7FC, 11'h7FE, 11'h7FD, 0);
    for (int i = 0; i < 6; i++)
      run_tile(int'($urandom_range(12, 1)), 1'($urandom_range(1)),
               ADDR_BW'($urandom), ADDR_BW'($urandom), ADDR_BW'($urandom), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
